// File: rtl/mem_stack_sequencer_if.sv
// mem_stack_sequencer_if: decode-side request and memory-side control bundle for the stack sequencer
interface mem_stack_sequencer_if #(parameter int STACK_DEPTH = 256);
  localparam int W = $clog2(STACK_DEPTH + 1);
  logic         i_start;
  logic [1:0]   i_op;
  logic         i_halt;
  logic         o_busy;
  logic         o_done;
  logic         o_err;
  logic [W-1:0] o_depth;
  logic         o_stackSel;
  logic         o_ctrlSpNEn;
  logic         o_ctrlSpUp;
  logic         o_ctrlRamNWE;
  logic         o_ctrlRamNOE;
  logic         o_ctrlMemPCToRamN;
  logic         o_ctrlPCLoadN;
  logic         o_ctrlPCFromImm;
  logic         o_regOE;
  logic         o_regWE;
  modport slave (
    input  i_start, i_op, i_halt,
    output o_busy, o_done, o_err, o_depth, o_stackSel, o_ctrlSpNEn, o_ctrlSpUp,
           o_ctrlRamNWE, o_ctrlRamNOE, o_ctrlMemPCToRamN, o_ctrlPCLoadN,
           o_ctrlPCFromImm, o_regOE, o_regWE
  );
  modport master (
    output i_start, i_op, i_halt,
    input  o_busy, o_done, o_err, o_depth, o_stackSel, o_ctrlSpNEn, o_ctrlSpUp,
           o_ctrlRamNWE, o_ctrlRamNOE, o_ctrlMemPCToRamN, o_ctrlPCLoadN,
           o_ctrlPCFromImm, o_regOE, o_regWE
  );
endinterface

// File: rtl/mem_stack_sequencer.sv
// mem_stack_sequencer: sequences SP steps, stack-RAM strobes and PC loads for PUSH/POP/CALL/RET
module mem_stack_sequencer #(
  parameter int STACK_DEPTH = 256
) (
  input logic                  i_clk,
  input logic                  i_reset,
  mem_stack_sequencer_if.slave bus
);
  localparam int W = $clog2(STACK_DEPTH + 1);
  typedef enum logic [3:0] {
    IDLE, PSH_WR, PSH_SP, POP_SP, POP_RD, CAL_WR, CAL_SP, CAL_JMP, RET_SP, RET_LD, ERR
  } state_t;
  state_t       state_q, state_d, first;
  logic [W-1:0] depth_q, depth_d;
  logic         err_q, err_d;
  logic         go, bad;
  assign go    = state_q == IDLE && bus.i_start && !bus.i_halt;
  assign bad   = bus.i_op[0] ? depth_q == '0 : depth_q == W'(STACK_DEPTH);
  assign first = bus.i_op == 2'b00 ? PSH_WR :
                 bus.i_op == 2'b01 ? POP_SP :
                 bus.i_op == 2'b10 ? CAL_WR : RET_SP;
  // state, depth and sticky error registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end
  // next state, depth stepping and error capture; everything holds while halted
  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    err_d   = go ? bad : err_q;
    if (!bus.i_halt) begin
      case (state_q)
        IDLE:    state_d = !bus.i_start ? IDLE : bad ? ERR : first;
        PSH_WR:  state_d = PSH_SP;
        PSH_SP:  begin state_d = IDLE;   depth_d = depth_q + W'(1); end
        POP_SP:  state_d = POP_RD;
        POP_RD:  begin state_d = IDLE;   depth_d = depth_q - W'(1); end
        CAL_WR:  state_d = CAL_SP;
        CAL_SP:  begin state_d = CAL_JMP; depth_d = depth_q + W'(1); end
        CAL_JMP: state_d = IDLE;
        RET_SP:  state_d = RET_LD;
        RET_LD:  begin state_d = IDLE;   depth_d = depth_q - W'(1); end
        default: state_d = IDLE;
      endcase
    end
  end
  // strobes decoded from the current state, all forced inactive while halted
  always_comb begin
    bus.o_busy            = state_q != IDLE;
    bus.o_err             = err_q;
    bus.o_depth           = depth_q;
    bus.o_done            = 1'b0;
    bus.o_stackSel        = 1'b0;
    bus.o_ctrlSpNEn       = 1'b1;
    bus.o_ctrlSpUp        = 1'b0;
    bus.o_ctrlRamNWE      = 1'b1;
    bus.o_ctrlRamNOE      = 1'b1;
    bus.o_ctrlMemPCToRamN = 1'b1;
    bus.o_ctrlPCLoadN     = 1'b1;
    bus.o_ctrlPCFromImm   = 1'b0;
    bus.o_regOE           = 1'b0;
    bus.o_regWE           = 1'b0;
    if (!bus.i_halt) begin
      case (state_q)
        PSH_WR: begin
          bus.o_stackSel   = 1'b1;
          bus.o_regOE      = 1'b1;
          bus.o_ctrlRamNWE = 1'b0;
        end
        PSH_SP, CAL_SP: begin
          bus.o_ctrlSpNEn = 1'b0;
          bus.o_done      = state_q == PSH_SP;
        end
        POP_SP, RET_SP: begin
          bus.o_ctrlSpNEn = 1'b0;
          bus.o_ctrlSpUp  = 1'b1;
        end
        POP_RD: begin
          bus.o_stackSel   = 1'b1;
          bus.o_ctrlRamNOE = 1'b0;
          bus.o_regWE      = 1'b1;
          bus.o_done       = 1'b1;
        end
        CAL_WR: begin
          bus.o_stackSel        = 1'b1;
          bus.o_ctrlMemPCToRamN = 1'b0;
          bus.o_ctrlRamNWE      = 1'b0;
        end
        CAL_JMP: begin
          bus.o_ctrlPCLoadN   = 1'b0;
          bus.o_ctrlPCFromImm = 1'b1;
          bus.o_done          = 1'b1;
        end
        RET_LD: begin
          bus.o_stackSel    = 1'b1;
          bus.o_ctrlRamNOE  = 1'b0;
          bus.o_ctrlPCLoadN = 1'b0;
          bus.o_done        = 1'b1;
        end
        ERR:     bus.o_done = 1'b1;
        default: bus.o_done = 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stack_sequencer.sv
// tb_mem_stack_sequencer: directed scoreboard bench for the stack sequencer
module tb_mem_stack_sequencer;
  localparam int DEPTH = 256;
  // strobe vector: {stackSel, SpNEn, SpUp, RamNWE, RamNOE, PCToRamN, PCLoadN, PCFromImm, regOE, regWE}
  localparam logic [9:0] IDLE_V = 10'b0101111000;
  localparam logic [9:0] SEQ [4][3] = '{
    '{10'b1100111010, 10'b0001111000, IDLE_V},
    '{10'b0011111000, 10'b1101011001, IDLE_V},
    '{10'b1100101000, 10'b0001111000, 10'b0101110100},
    '{10'b0011111000, 10'b1101010000, IDLE_V}
  };
  localparam int LAT [4] = '{2, 2, 3, 2};
  typedef struct { int depth; bit err; } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int passed = 0;
  int total = 0;
  int m_depth = 0;
  bit m_err = 1'b0;
  exp_t sb[$];
  mem_stack_sequencer_if #(.STACK_DEPTH(DEPTH)) bus ();
  mem_stack_sequencer #(.STACK_DEPTH(DEPTH)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [9:0] strobes();
    return {bus.o_stackSel, bus.o_ctrlSpNEn, bus.o_ctrlSpUp, bus.o_ctrlRamNWE, bus.o_ctrlRamNOE,
            bus.o_ctrlMemPCToRamN, bus.o_ctrlPCLoadN, bus.o_ctrlPCFromImm, bus.o_regOE, bus.o_regWE};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic run_op(input logic [1:0] op, input bit full_check);
    exp_t e;
    bit er;
    int lat;
    er = op[0] ? m_depth == 0 : m_depth == DEPTH;
    if (!er) m_depth += op[0] ? -1 : 1;
    m_err = er;
    sb.push_back('{m_depth, m_err});
    lat = er ? 1 : LAT[op];
    bus.i_start = 1'b1;
    bus.i_op = op;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    for (int k = 0; k < lat; k++) begin
      if (full_check || er) begin
        chk($sformatf("strobes op%0d c%0d", op, k), strobes(), er ? IDLE_V : SEQ[op][k]);
        chk($sformatf("busy op%0d c%0d", op, k), bus.o_busy, 1);
      end
      chk($sformatf("done op%0d c%0d", op, k), bus.o_done, k == lat - 1);
      if (k < lat - 1) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    e = sb.pop_front();
    chk($sformatf("depth after op%0d", op), bus.o_depth, e.depth);
    chk($sformatf("err after op%0d", op), bus.o_err, e.err);
    if (full_check) chk($sformatf("idle after op%0d", op), bus.o_busy, 0);
  endtask
  initial begin
    bus.i_start = 1'b0;
    bus.i_op = 2'b00;
    bus.i_halt = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset busy", bus.o_busy, 0);
    chk("reset done", bus.o_done, 0);
    chk("reset err", bus.o_err, 0);
    chk("reset depth", bus.o_depth, 0);
    chk("reset strobes", strobes(), IDLE_V);
    run_op(2'b10, 1);
    run_op(2'b11, 1);
    run_op(2'b01, 1);
    run_op(2'b00, 1);
    bus.i_start = 1'b1;
    bus.i_halt = 1'b1;
    bus.i_op = 2'b00;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    bus.i_halt = 1'b0;
    #1;
    chk("start+halt dropped busy", bus.o_busy, 0);
    chk("start+halt dropped depth", bus.o_depth, m_depth);
    bus.i_start = 1'b1;
    bus.i_op = 2'b10;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    chk("halt test cal_wr", strobes(), SEQ[2][0]);
    @(posedge clk); #1;
    bus.i_halt = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("halt spnen c%0d", k), bus.o_ctrlSpNEn, 1);
      chk($sformatf("halt strobes c%0d", k), strobes(), IDLE_V);
      chk($sformatf("halt depth c%0d", k), bus.o_depth, m_depth);
      @(posedge clk); #1;
    end
    bus.i_halt = 1'b0;
    #1;
    chk("halt release cal_sp", strobes(), SEQ[2][1]);
    chk("halt release depth", bus.o_depth, m_depth);
    @(posedge clk); #1;
    m_depth++;
    chk("halt cal_jmp", strobes(), SEQ[2][2]);
    chk("halt cal_jmp done", bus.o_done, 1);
    chk("halt depth once", bus.o_depth, m_depth);
    @(posedge clk); #1;
    chk("halt idle busy", bus.o_busy, 0);
    chk("halt final depth", bus.o_depth, m_depth);
    bus.i_start = 1'b1;
    bus.i_op = 2'b10;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    @(posedge clk); #1;
    chk("pre-reset in cal_sp", bus.o_ctrlSpNEn, 0);
    rst = 1'b1;
    #1;
    chk("mid-op reset strobes", strobes(), IDLE_V);
    chk("mid-op reset depth", bus.o_depth, 0);
    chk("mid-op reset busy", bus.o_busy, 0);
    chk("mid-op reset done", bus.o_done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_depth = 0;
    m_err = 1'b0;
    sb.delete();
    for (int i = 0; i < DEPTH; i++) run_op(2'b00, i < 2 || i == DEPTH - 1);
    chk("full depth", bus.o_depth, DEPTH);
    run_op(2'b00, 1);
    run_op(2'b10, 1);
    chk("overflow keeps depth", bus.o_depth, DEPTH);
    run_op(2'b01, 1);
    run_op(2'b11, 1);
    chk("queue drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1);
  end
endmodule
